// File: rtl/sobel_pkg.sv
// sobel_pkg: image geometry, datapath widths and shared types for the Sobel
// readout path. The FSM, address generator and readout all import the same
// constants so the frame geometry has exactly one definition.
//   IMG_W / IMG_H / NUM_PIX : frame geometry (raster order, one entry per pixel)
//   ADDR_W                  : result memory address width
//   PIX_W                   : width of Gx, Gy and the output magnitude
package sobel_pkg;

  localparam int IMG_W   = 32;
  localparam int IMG_H   = 32;
  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int ADDR_W  = 10;
  localparam int PIX_W   = 4;

  // One buffered output pixel: magnitude plus start/end-of-line and end-of-frame.
  localparam int FIFO_W  = PIX_W + 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sol;
    logic             eol;
    logic             eof;
  } pix_entry_t;

  // |Gx|+|Gy| clamped to the all-ones code when the PIX_W+1 bit sum carries.
  function automatic logic [PIX_W-1:0] sat_add(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b);
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIX_W] ? {PIX_W{1'b1}} : s[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/sobel_readout_if.sv
// sobel_readout_if: raster pixel stream from the Sobel readout to the
// display/UART sink.
//   pix_valid/pix_ready : handshake
//   pix_data            : saturated gradient magnitude
//   pix_sol/eol/eof     : start-of-line, end-of-line, end-of-frame markers
//
// Handshake: a beat transfers on a rising clk edge where pix_valid and
// pix_ready are both high. Once pix_valid is raised, pix_data and the markers
// hold stable and pix_valid stays high until that transfer happens; pix_valid
// never depends on pix_ready, pix_ready may depend on pix_valid.
interface sobel_readout_if;

  logic                        pix_valid;
  logic                        pix_ready;
  logic [sobel_pkg::PIX_W-1:0] pix_data;
  logic                        pix_sol;
  logic                        pix_eol;
  logic                        pix_eof;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_sol,
    output pix_eol,
    output pix_eof,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_sol,
    input  pix_eol,
    input  pix_eof,
    output pix_ready
  );

endinterface

// File: rtl/readout_skid_fifo.sv
// readout_skid_fifo: 2-entry synchronous FIFO that absorbs the one-cycle
// memory read latency so the readout can stream at full rate under backpressure.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write one entry (ignored when full and not popping)
//   pop/pop_data   : pop_data is the head; pop removes it (ignored when empty)
//   count          : current occupancy, 0..2
module readout_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  // A full FIFO may still accept a push in the same cycle it pops.
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sobel_readout.sv
// sobel_readout: drains the Gx/Gy result memories after the Sobel pass and
// streams saturated magnitudes in raster order.
//   clk, rst        : clock, synchronous active-high reset (aborts a frame)
//   start           : one-cycle pulse, accepted only in IDLE
//   rd_en, rd_addr  : shared read strobe/address for Gx and Gy memories
//   gx_data,gy_data : memory read data, valid one cycle after rd_en
//   pix             : output pixel stream (master side)
//   busy, done      : busy from the cycle after start; done pulses after the
//                     last pixel has been accepted
//   dbg_state, dbg_fifo_count : FSM state and skid FIFO occupancy
module sobel_readout
  import sobel_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   gx_data,
  input  logic [PIX_W-1:0]   gy_data,
  sobel_readout_if.master    pix,
  output logic               busy,
  output logic               done,
  output rd_state_e          dbg_state,
  output logic [1:0]         dbg_fifo_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);

  rd_state_e         state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] inflight_addr_q;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;

  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        credit_used;
  logic [2:0]        credit_limit;
  logic [ADDR_W-1:0] col;
  pix_entry_t        push_entry;
  pix_entry_t        head_entry;

  assign pop = pix.pix_valid && pix.pix_ready;

  // Slots already spoken for: buffered entries plus the read whose data is on
  // the bus this cycle. A pop this cycle frees one slot in time for the data
  // of a read issued now, which is what lets the stream run at one pixel per
  // cycle while never overflowing the two entries.
  assign credit_used  = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_limit = pop ? 3'd3 : 3'd2;
  assign rd_en        = (state_q == ST_READ) && (credit_used < credit_limit);

  // Markers are derived from the address of the returning read so they travel
  // through the FIFO alongside the magnitude.
  assign col             = inflight_addr_q % IMG_W_A;
  assign push_entry.data = sat_add(gx_data, gy_data);
  assign push_entry.sol  = (col == '0);
  assign push_entry.eol  = (col == IMG_W_A - ADDR_W'(1));
  assign push_entry.eof  = (inflight_addr_q == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      rd_addr_q       <= '0;
      inflight_addr_q <= '0;
      inflight_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (rd_en) begin
        inflight_addr_q <= rd_addr_q;
      end
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_READ;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_en) begin
            // The address parks on the last pixel rather than wrapping.
            if (rd_addr_q == LAST_ADDR) begin
              state_q <= ST_DRAIN;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // Finish on the edge that accepts the final pixel so done follows
          // the last handshake by exactly one cycle.
          if (!inflight_q &&
              ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop))) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  readout_skid_fifo #(
    .W (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .count     (fifo_count)
  );

  assign pix.pix_valid = (fifo_count != 2'd0);
  assign pix.pix_data  = head_entry.data;
  assign pix.pix_sol   = head_entry.sol;
  assign pix.pix_eol   = head_entry.eol;
  assign pix.pix_eof   = head_entry.eof;

  assign rd_addr        = rd_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign dbg_state      = state_q;
  assign dbg_fifo_count = fifo_count;

endmodule
